// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared ALU opcodes, sequencer state codes and instruction
//               field positions for the ALU issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_ADDC = 3'b001,
      OP_SUB  = 3'b010,
      OP_MUL  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_NOT  = 3'b110,
      OP_XOR  = 3'b111
   } alu_op_e;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam int INSTR_LOAD_BIT = 15;
   localparam int INSTR_OP_MSB   = 14;
   localparam int INSTR_OP_LSB   = 12;
   localparam int INSTR_RD_MSB   = 11;
   localparam int INSTR_RD_LSB   = 10;
   localparam int INSTR_RS_MSB   = 9;
   localparam int INSTR_RS_LSB   = 8;
   localparam int INSTR_IMM_MSB  = 7;
   localparam int INSTR_IMM_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_if
// Description : Instruction and response valid/ready channels of the issue
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             instr_valid;
   logic             instr_ready;
   logic [15:0]      instr;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_carry;

   modport master (
      output instr_valid, instr, resp_ready,
      input  instr_ready, resp_valid, resp_data, resp_carry
   );

   modport slave (
      input  instr_valid, instr, resp_ready,
      output instr_ready, resp_valid, resp_data, resp_carry
   );
endinterface
`default_nettype wire

// File: rtl/alu_regfile4.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile4
// Description : Register file with two operand read ports, a debug read port
//               and one synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile4 #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  wire                     clk,
   input  wire                     rst,
   input  wire                     i_we,
   input  wire [$clog2(NREGS)-1:0] i_waddr,
   input  wire [WIDTH-1:0]         i_wdata,
   input  wire [$clog2(NREGS)-1:0] i_raddr_a,
   input  wire [$clog2(NREGS)-1:0] i_raddr_b,
   input  wire [$clog2(NREGS)-1:0] i_dbg_addr,
   output logic [WIDTH-1:0]        o_rdata_a,
   output logic [WIDTH-1:0]        o_rdata_b,
   output logic [WIDTH-1:0]        o_dbg_data
);
   logic [WIDTH-1:0] r_regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a  = r_regs[i_raddr_a];
   assign o_rdata_b  = r_regs[i_raddr_b];
   assign o_dbg_data = r_regs[i_dbg_addr];
endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issues register-file instructions to an external ALU, writes
//               the result back and returns it on a response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  wire                    clk,
   input  wire                    reset,
   alu_issue_ctrl_if.slave        bus,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic                   alu_carryin,
   output logic [2:0]             alu_op_sel,
   input  wire  [WIDTH-1:0]       alu_result,
   input  wire                    alu_carryout,
   input  wire  [1:0]             dbg_addr,
   output logic [WIDTH-1:0]       dbg_data
);
   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic             w_instr_ready;
   logic             w_resp_valid;
   logic             w_rf_we;
   logic             w_accept;
   logic             w_is_load;

   logic             r_load;
   logic [1:0]       r_rd;
   logic [7:0]       r_imm;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   alu_op_e          r_alu_op_sel;
   logic [WIDTH-1:0] r_hold_result;
   logic             r_hold_carry;
   logic             r_carry;
   logic [WIDTH-1:0] r_resp_data;
   logic             r_resp_carry;

   logic [WIDTH-1:0] w_rd_data;
   logic [WIDTH-1:0] w_rs_data;
   logic [WIDTH-1:0] w_wb_data;
   logic             w_wb_carry;

   assign w_is_load = bus.instr[INSTR_LOAD_BIT];
   assign w_accept  = bus.instr_valid && w_instr_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = w_is_load ? S_WB : S_EXEC;
         S_EXEC:  w_next_state = S_WB;
         S_WB:    w_next_state = S_RESP;
         S_RESP:  if (bus.resp_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_instr_ready = 1'b0;
      w_resp_valid  = 1'b0;
      w_rf_we       = 1'b0;
      case (r_state)
         S_IDLE:  w_instr_ready = !reset;
         S_WB:    w_rf_we       = 1'b1;
         S_RESP:  w_resp_valid  = 1'b1;
         default: ;
      endcase
   end

   // Loads bypass the ALU and leave the carry flag untouched.
   assign w_wb_data  = r_load ? WIDTH'(r_imm) : r_hold_result;
   assign w_wb_carry = r_load ? r_carry : r_hold_carry;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_load        <= 1'b0;
         r_rd          <= '0;
         r_imm         <= '0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op_sel  <= OP_ADD;
         r_hold_result <= '0;
         r_hold_carry  <= 1'b0;
         r_carry       <= 1'b0;
         r_resp_data   <= '0;
         r_resp_carry  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_load <= w_is_load;
            r_rd   <= bus.instr[INSTR_RD_MSB:INSTR_RD_LSB];
            r_imm  <= bus.instr[INSTR_IMM_MSB:INSTR_IMM_LSB];
            if (!w_is_load) begin
               r_alu_a      <= w_rd_data;
               r_alu_b      <= w_rs_data;
               r_alu_op_sel <= alu_op_e'(bus.instr[INSTR_OP_MSB:INSTR_OP_LSB]);
            end
         end
         if (r_state == S_EXEC) begin
            r_hold_result <= alu_result;
            r_hold_carry  <= alu_carryout;
         end
         if (w_rf_we) begin
            r_carry      <= w_wb_carry;
            r_resp_data  <= w_wb_data;
            r_resp_carry <= w_wb_carry;
         end
      end
   end

   alu_regfile4 #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_regfile (
      .clk        (clk),
      .rst        (reset),
      .i_we       (w_rf_we),
      .i_waddr    (r_rd),
      .i_wdata    (w_wb_data),
      .i_raddr_a  (bus.instr[INSTR_RD_MSB:INSTR_RD_LSB]),
      .i_raddr_b  (bus.instr[INSTR_RS_MSB:INSTR_RS_LSB]),
      .i_dbg_addr (dbg_addr),
      .o_rdata_a  (w_rd_data),
      .o_rdata_b  (w_rs_data),
      .o_dbg_data (dbg_data)
   );

   assign bus.instr_ready = w_instr_ready;
   assign bus.resp_valid  = w_resp_valid;
   assign bus.resp_data   = r_resp_data;
   assign bus.resp_carry  = r_resp_carry;
   assign alu_a           = r_alu_a;
   assign alu_b           = r_alu_b;
   assign alu_op_sel      = r_alu_op_sel;
   assign alu_carryin     = r_carry;
endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-side sequencer for the 8-bit ALU datapath in the 8bit_cpu tree.
- Accepts 16-bit instructions over a valid/ready handshake and holds a 4-entry register file plus a carry flag.
- Drives the ALU's operand, carry-in and op_sel inputs, then captures the ALU result and carry-out.
- Writes the result back to the register file and returns it on a valid/ready response channel.
- The ALU itself stays a separate combinational instance that this block wraps.

Parameters:
- WIDTH, 8, datapath and register width; must match the ALU operand width.
- NREGS, 4, register-file depth; fixed at 4 because the instruction encoding has 2-bit register fields.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  block can accept an instruction.
- instr  input  16  instruction word:
  - [15] load
  - [14:12] op
  - [11:10] rd
  - [9:8] rs
  - [7:0] imm
- alu_a  output  WIDTH  operand A to the ALU (registered).
- alu_b  output  WIDTH  operand B to the ALU (registered).
- alu_carryin  output  1  current carry flag.
- alu_op_sel  output  3  ALU operation select (registered).
- alu_result  input  WIDTH  ALU result.
- alu_carryout  input  1  ALU carry/borrow/overflow flag.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  WIDTH  value written to rd.
- resp_carry  output  1  carry flag after the instruction.
- dbg_addr  input  2  register-file debug read address.
- dbg_data  output  WIDTH  combinational read of regfile[dbg_addr].

Behaviour:
- Reset: synchronous, active-high; takes effect on any clk edge with reset=1 and overrides every state.
  - State goes to IDLE.
  - All registers are cleared to 0 and the carry flag to 0.
  - instr_ready=0 while reset is asserted, then 1 in IDLE.
  - alu_a, alu_b, alu_op_sel, resp_data and resp_carry go to 0; resp_valid goes to 0.
  - Reset mid-operation discards the in-flight instruction with no regfile write and no response.
- State machine: IDLE -> EXEC -> WB -> RESP -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr.
  - ALU instruction: load alu_a<=reg[rd], alu_b<=reg[rs], alu_op_sel<=op, then go to EXEC.
  - Load instruction: go straight to WB with imm as the writeback value.
- EXEC:
  - Exactly one cycle; the ALU settles combinationally.
  - alu_carryin is driven from the carry flag register.
- WB:
  - ALU instruction: reg[rd]<=alu_result (value sampled in EXEC), carry<=alu_carryout.
  - Load instruction: reg[rd]<=imm; carry unchanged.
  - resp_data and resp_carry take the new values. Go to RESP.
  - Implementation note: sample alu_result/alu_carryout at the end of EXEC into a holding register; WB commits it.
- RESP:
  - resp_valid=1; resp_data and resp_carry held stable until resp_ready=1.
  - On resp_valid&&resp_ready, go to IDLE.
  - instr_ready=0 throughout RESP (no overlap).
- Latency: accept edge to resp_valid high.
  - ALU instruction: 3 cycles.
  - Load instruction: 2 cycles.
  - With resp_ready tied 1, throughput is one instruction per 4 cycles (ALU) or 3 cycles (load).
- Carry semantics are the ALU's own:
  - op 000/001/010: carry or borrow, 9-bit.
  - op 011: product overflow (any bit of product[15:8] set).
  - ops 100-111: carry cleared.
  - The carry flag always updates on ALU instructions, including logic ops.
- rd==rs is legal; both operands read the same pre-write value.
- dbg_data reflects writes from the cycle after the WB edge.
- Unused instr bits: imm is ignored for ALU instructions; op and rs are ignored for loads.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU op constants: OP_ADD=000, OP_ADDC=001, OP_SUB=010, OP_MUL=011, OP_AND=100, OP_OR=101, OP_NOT=110, OP_XOR=111.
  - State encoding constants S_IDLE, S_EXEC, S_WB, S_RESP.
  - Instruction field bit positions.
- One natural sub-module: alu_regfile4.
  - 4xWIDTH registers with two combinational read ports (operands) and one debug read port.
  - One synchronous write port.
  - Synchronous reset to 0.
- The FSM stays in alu_issue_ctrl.

Test Plan:
- Reset, then: load r0=0xF0, load r1=0x20, ADD rd=0 rs=1 -> resp_data=0x10, resp_carry=1, dbg r0=0x10; ADD response appears 3 cycles after accept.
- With carry=1, r2=0: ADDC rd=2 rs=2 -> resp_data=0x01, resp_carry=0 (carry-in consumed).
- r1=0x20, r0=0xF0: SUB rd=1 rs=0 -> resp_data=0x30, resp_carry=1 (borrow); then load r3=0x05 -> carry stays 1.
- r0=0x10, r1=0x20: MUL rd=0 rs=1 -> resp_data=0x00, resp_carry=1; then AND rd=1 rs=1 -> resp_data=0x20, resp_carry=0.
- Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_data stable, instr_ready=0, a new instr_valid is not accepted; release -> accepted on the next IDLE cycle.
- Assert reset during EXEC of ADD rd=0 -> next cycle instr_ready=1, resp_valid=0, r0=0, carry=0, no response ever emitted for that instruction.
